rx_mdpx_packetizer: RTL and testbench

Parametrised single-clock successor to the Medipix receive path. Deserialises a 1/2/4/8-lane Medipix readout stream into bytes and buffers them in an internal FIFO. Emits fixed-length byte packets with sync/valid/last framing and downstream backpressure to the UDP/Ethernet packet builder. Frame-end flush, overflow reporting and tail packets are handled internally, so no external FIFO-reader block is needed.

---
 rtl/rx_mdpx_packetizer.sv | 191 +++++++++++++++++++
 tb/tb_rx_mdpx_packetizer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_mdpx_packetizer.sv
// Medipix receive path: lane deserialiser, byte FIFO and fixed-length packet framer
// with frame-end flush, tail packets, backpressure and sticky overflow.
`timescale 1ns/1ps
module rx_mdpx_packetizer #(
   parameter int unsigned LANES     = 8,
   parameter int unsigned FIFO_AW   = 10,
   parameter int unsigned PLEN_W    = 11,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              In_Clk,
   input  logic              In_Reset,
   input  logic              In_Bit_Strobe,
   input  logic              In_En_Mdpx,
   input  logic [LANES-1:0]  In_Data_Mdpx,
   input  logic [PLEN_W-1:0] In_Packet_Length,
   input  logic              In_Ready,
   output logic              Out_Sync,
   output logic              Out_Valid,
   output logic              Out_Last,
   output logic [7:0]        Out_Data,
   output logic              Out_Overflow,
   output logic [FIFO_AW:0]  Out_Fifo_Level
);

   localparam int unsigned GROUPS = 8 / LANES;
   localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int unsigned DEPTH  = 2 ** FIFO_AW;
   localparam int unsigned LW     = FIFO_AW + 1;
   localparam int unsigned CW     = (PLEN_W > LW) ? PLEN_W : LW;

   typedef enum logic {IDLE, SEND} state_t;

   logic [7:0]         sh_q;
   logic [GW-1:0]      grp_q;
   logic               en_q;
   logic               wr_valid_q;
   logic [7:0]         wr_byte_q;
   logic               close_q;
   logic [7:0]         data_ext, shifted, padded;
   int unsigned        pad_amt;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0]      level_q, level_d, closed_q;
   logic               do_wr, do_rd;

   state_t             state_q, state_d;
   logic [CW-1:0]      plen_q, issued_q, l_eff, start_len, load_idx, load_len;
   logic               start, load, xfer;

   always_comb begin
      data_ext = 8'(In_Data_Mdpx);
      pad_amt  = LANES * (GROUPS - 32'(grp_q));
      if (MSB_FIRST) begin
         shifted = (sh_q << LANES) | data_ext;
         padded  = sh_q << pad_amt;
      end else begin
         shifted = (sh_q >> LANES) | (data_ext << (8 - LANES));
         padded  = sh_q >> pad_amt;
      end
   end

   // Completed or padded bytes wait one cycle in wr_byte_q; the close flag lines up with the pad write.
   always_ff @(posedge In_Clk) begin
      if (In_Reset) begin
         sh_q       <= '0;
         grp_q      <= '0;
         en_q       <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_byte_q  <= '0;
         close_q    <= 1'b0;
      end else begin
         en_q       <= In_En_Mdpx;
         wr_valid_q <= 1'b0;
         close_q    <= 1'b0;
         if (In_Bit_Strobe && In_En_Mdpx) begin
            if (grp_q == GW'(GROUPS - 1)) begin
               wr_valid_q <= 1'b1;
               wr_byte_q  <= shifted;
               grp_q      <= '0;
               sh_q       <= '0;
            end else begin
               sh_q  <= shifted;
               grp_q <= grp_q + 1'b1;
            end
         end else if (en_q && !In_En_Mdpx) begin
            close_q <= 1'b1;
            if (grp_q != '0) begin
               wr_valid_q <= 1'b1;
               wr_byte_q  <= padded;
               grp_q      <= '0;
               sh_q       <= '0;
            end
         end
      end
   end

   always_comb begin
      do_rd   = load;
      do_wr   = wr_valid_q && ((level_q != LW'(DEPTH)) || do_rd);
      level_d = level_q;
      if (do_wr && !do_rd)
         level_d = level_q + 1'b1;
      else if (!do_wr && do_rd)
         level_d = level_q - 1'b1;
   end

   // Closed bytes always sit at the FIFO head, so the whole post-update occupancy is closed.
   always_ff @(posedge In_Clk) begin
      if (In_Reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level_q      <= '0;
         closed_q     <= '0;
         Out_Overflow <= 1'b0;
      end else begin
         level_q <= level_d;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (wr_valid_q && !do_wr) Out_Overflow <= 1'b1;
         if (close_q)
            closed_q <= level_d;
         else if (do_rd && closed_q != '0)
            closed_q <= closed_q - 1'b1;
      end
   end

   always_ff @(posedge In_Clk) begin
      if (do_wr) mem[wr_ptr] <= wr_byte_q;
   end

   always_comb begin
      l_eff     = (In_Packet_Length == '0) ? CW'(1) : CW'(In_Packet_Length);
      start     = 1'b0;
      start_len = l_eff;
      if (state_q == IDLE) begin
         if (closed_q != '0) begin
            start = 1'b1;
            if (CW'(closed_q) < l_eff) start_len = CW'(closed_q);
         end else if (CW'(level_q) >= l_eff) begin
            start = 1'b1;
         end
      end
      xfer = Out_Valid && In_Ready;
      // The first byte is fetched in the deciding IDLE cycle to keep inter-packet gaps short.
      if (state_q == IDLE) begin
         load     = start;
         load_idx = '0;
         load_len = start_len;
      end else begin
         load     = (issued_q < plen_q) && (!Out_Valid || In_Ready);
         load_idx = issued_q;
         load_len = plen_q;
      end
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SEND;
         SEND:    if (xfer && Out_Last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge In_Clk) begin
      if (In_Reset) begin
         state_q   <= IDLE;
         plen_q    <= '0;
         issued_q  <= '0;
         Out_Valid <= 1'b0;
         Out_Sync  <= 1'b0;
         Out_Last  <= 1'b0;
         Out_Data  <= '0;
      end else begin
         state_q <= state_d;
         if (start) plen_q <= start_len;
         if (load) begin
            issued_q  <= load_idx + 1'b1;
            Out_Valid <= 1'b1;
            Out_Data  <= mem[rd_ptr];
            Out_Sync  <= (load_idx == '0);
            Out_Last  <= (load_idx == load_len - 1'b1);
         end else if (xfer) begin
            Out_Valid <= 1'b0;
            Out_Sync  <= 1'b0;
            Out_Last  <= 1'b0;
         end
      end
   end

   assign Out_Fifo_Level = level_q;

endmodule

// File: tb/tb_rx_mdpx_packetizer.sv
// Directed bench for rx_mdpx_packetizer: three lane configurations share one stimulus set.
`timescale 1ns/1ps
module tb_rx_mdpx_packetizer;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        strobe = 1'b0;
   logic        en     = 1'b0;
   logic        ready  = 1'b0;
   logic [10:0] plen   = '0;
   logic [7:0]  data8  = '0;
   logic [0:0]  data1  = '0;
   logic [3:0]  data4  = '0;

   logic        s8, v8, l8, ov8, s1, v1, l1, ov1, s4, v4, l4, ov4;
   logic [7:0]  d8, d1, d4;
   logic [4:0]  lv8;
   logic [10:0] lv1, lv4;

   int          sel = 0;
   logic        o_valid, o_sync, o_last;
   logic [7:0]  o_data;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [9:0]  xq[$];
   int          stall_seen = 0;
   int          stall_bad  = 0;
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_word  = '0;
   logic [9:0]  got, exp;
   int          base;

   always #5 clk = ~clk;

   rx_mdpx_packetizer #(.LANES(8), .FIFO_AW(4), .PLEN_W(11), .MSB_FIRST(1'b1)) dut8 (
      .In_Clk(clk), .In_Reset(rst), .In_Bit_Strobe(strobe), .In_En_Mdpx(en),
      .In_Data_Mdpx(data8), .In_Packet_Length(plen), .In_Ready(ready),
      .Out_Sync(s8), .Out_Valid(v8), .Out_Last(l8), .Out_Data(d8),
      .Out_Overflow(ov8), .Out_Fifo_Level(lv8));

   rx_mdpx_packetizer #(.LANES(1), .FIFO_AW(10), .PLEN_W(11), .MSB_FIRST(1'b1)) dut1 (
      .In_Clk(clk), .In_Reset(rst), .In_Bit_Strobe(strobe), .In_En_Mdpx(en),
      .In_Data_Mdpx(data1), .In_Packet_Length(plen), .In_Ready(ready),
      .Out_Sync(s1), .Out_Valid(v1), .Out_Last(l1), .Out_Data(d1),
      .Out_Overflow(ov1), .Out_Fifo_Level(lv1));

   rx_mdpx_packetizer #(.LANES(4), .FIFO_AW(10), .PLEN_W(11), .MSB_FIRST(1'b1)) dut4 (
      .In_Clk(clk), .In_Reset(rst), .In_Bit_Strobe(strobe), .In_En_Mdpx(en),
      .In_Data_Mdpx(data4), .In_Packet_Length(plen), .In_Ready(ready),
      .Out_Sync(s4), .Out_Valid(v4), .Out_Last(l4), .Out_Data(d4),
      .Out_Overflow(ov4), .Out_Fifo_Level(lv4));

   always_comb begin
      case (sel)
         0:       begin o_valid = v8; o_sync = s8; o_last = l8; o_data = d8; end
         1:       begin o_valid = v1; o_sync = s1; o_last = l1; o_data = d1; end
         default: begin o_valid = v4; o_sync = s4; o_last = l4; o_data = d4; end
      endcase
   end

   // Log every handshake of the selected DUT and watch that stalled bytes do not change.
   always @(negedge clk) begin
      if (!rst && prev_stall) begin
         stall_seen++;
         if (!o_valid || {o_sync, o_last, o_data} !== prev_word) stall_bad++;
      end
      prev_stall = o_valid && !ready && !rst;
      prev_word  = {o_sync, o_last, o_data};
      if (o_valid && ready && !rst) xq.push_back({o_sync, o_last, o_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; strobe = 1'b0; en = 1'b0; ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic strobe_byte(input logic [7:0] b8, input logic b1, input logic [3:0] b4);
      strobe = 1'b1; data8 = b8; data1 = b1; data4 = b4;
      tick();
      strobe = 1'b0;
      tick();
   endtask

   task automatic wait_xfers(input int from, input int n, input int budget);
      for (int c = 0; c < budget && (xq.size() - from) < n; c++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({v8, s8, l8, ov8, d8, lv8} !== '0) begin
         tests_failed++;
         $display("FAIL reset_dut8: got %h required 0", {v8, s8, l8, ov8, d8, lv8});
      end
      tests_run++;
      if ({v1, s1, l1, ov1, d1, lv1} !== '0) begin
         tests_failed++;
         $display("FAIL reset_dut1: got %h required 0", {v1, s1, l1, ov1, d1, lv1});
      end
      tests_run++;
      if ({v4, s4, l4, ov4, d4, lv4} !== '0) begin
         tests_failed++;
         $display("FAIL reset_dut4: got %h required 0", {v4, s4, l4, ov4, d4, lv4});
      end
      rst = 1'b0;
   endtask

   task automatic test_lanes8_packets();
      sel = 0;
      apply_reset();
      plen = 11'd4; ready = 1'b1; en = 1'b1;
      base = xq.size();
      tick();
      for (int i = 0; i < 8; i++) strobe_byte(8'(i), 1'b0, 4'h0);
      wait_xfers(base, 8, 60);
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (xq.size() - base !== 8) begin
         tests_failed++;
         $display("FAIL l8_count: got %0d required 8", xq.size() - base);
      end
      for (int i = 0; i < 8; i++) begin
         exp = {(i % 4) == 0, (i % 4) == 3, 8'(i)};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL l8_byte%0d: got %h required %h", i, got, exp);
         end
      end
      tests_run++;
      if (ov8 !== 1'b0 || lv8 !== 5'd0) begin
         tests_failed++;
         $display("FAIL l8_ovf_level: got ovf=%b level=%0d required ovf=0 level=0", ov8, lv8);
      end
   endtask

   task automatic test_lanes1_tail();
      logic [11:0] bits;
      sel = 1;
      apply_reset();
      bits = 12'b1010_0101_1011;
      plen = 11'd16; ready = 1'b1; en = 1'b1;
      base = xq.size();
      tick();
      for (int i = 0; i < 12; i++) strobe_byte(8'h00, bits[11 - i], 4'h0);
      en = 1'b0;
      wait_xfers(base, 2, 40);
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (xq.size() - base !== 2) begin
         tests_failed++;
         $display("FAIL tail_count: got %0d required 2", xq.size() - base);
      end
      for (int i = 0; i < 2; i++) begin
         exp = (i == 0) ? {1'b1, 1'b0, 8'hA5} : {1'b0, 1'b1, 8'hB0};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL tail_byte%0d: got %h required %h", i, got, exp);
         end
      end
      tests_run++;
      if (lv1 !== 11'd0) begin
         tests_failed++;
         $display("FAIL tail_level: got %0d required 0", lv1);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] bytes [6];
      logic [7:0] b;
      int         k, s0, b0;
      sel = 2;
      apply_reset();
      bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      plen = 11'd3; en = 1'b1;
      base = xq.size();
      s0 = stall_seen; b0 = stall_bad; k = 0;
      for (int c = 0; c < 200 && (xq.size() - base) < 6; c++) begin
         ready = (c % 2) == 1;
         if ((c % 2) == 0 && k < 12) begin
            b      = bytes[k / 2];
            data4  = ((k % 2) == 0) ? b[7:4] : b[3:0];
            strobe = 1'b1;
            k++;
         end else begin
            strobe = 1'b0;
         end
         tick();
      end
      strobe = 1'b0; ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      tests_run++;
      if (xq.size() - base !== 6) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d required 6", xq.size() - base);
      end
      for (int i = 0; i < 6; i++) begin
         exp = {(i % 3) == 0, (i % 3) == 2, bytes[i]};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL bp_byte%0d: got %h required %h", i, got, exp);
         end
      end
      tests_run++;
      if (stall_bad - b0 !== 0) begin
         tests_failed++;
         $display("FAIL bp_stall_stable: got %0d changes required 0", stall_bad - b0);
      end
      tests_run++;
      if (stall_seen - s0 == 0) begin
         tests_failed++;
         $display("FAIL bp_stall_seen: got 0 stalled cycles required >0");
      end
   endtask

   task automatic test_overflow();
      sel = 0;
      apply_reset();
      plen = 11'd100; ready = 1'b0; en = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) strobe_byte(8'h40 + 8'(i), 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) tick();
      tests_run++;
      if (lv8 !== 5'd16) begin
         tests_failed++;
         $display("FAIL ovf_level: got %0d required 16", lv8);
      end
      tests_run++;
      if (ov8 !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_flag: got %b required 1", ov8);
      end
      base = xq.size();
      ready = 1'b1; en = 1'b0;
      wait_xfers(base, 16, 80);
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (xq.size() - base !== 16) begin
         tests_failed++;
         $display("FAIL ovf_count: got %0d required 16", xq.size() - base);
      end
      for (int i = 0; i < 16; i++) begin
         exp = {i == 0, i == 15, 8'h40 + 8'(i)};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL ovf_byte%0d: got %h required %h", i, got, exp);
         end
      end
      tests_run++;
      if (ov8 !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: got %b required 1", ov8);
      end
   endtask

   task automatic test_reset_mid_packet();
      sel = 0;
      apply_reset();
      plen = 11'd4; ready = 1'b1; en = 1'b1;
      base = xq.size();
      tick();
      for (int i = 0; i < 4; i++) strobe_byte(8'h10 + 8'(i), 1'b0, 4'h0);
      wait_xfers(base, 2, 40);
      rst = 1'b1; en = 1'b0;
      tick();
      tests_run++;
      if ({v8, s8, l8, ov8, d8} !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got %h required 0", {v8, s8, l8, ov8, d8});
      end
      tests_run++;
      if (lv8 !== 5'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_level: got %0d required 0", lv8);
      end
      tests_run++;
      if (xq.size() - base !== 2) begin
         tests_failed++;
         $display("FAIL mid_reset_pre_count: got %0d required 2", xq.size() - base);
      end
      for (int i = 0; i < 2; i++) begin
         exp = {i == 0, 1'b0, 8'h10 + 8'(i)};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_pre%0d: got %h required %h", i, got, exp);
         end
      end
      rst = 1'b0;
      tick();
      base = xq.size();
      en = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) strobe_byte(8'h20 + 8'(i), 1'b0, 4'h0);
      wait_xfers(base, 4, 40);
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (xq.size() - base !== 4) begin
         tests_failed++;
         $display("FAIL mid_reset_post_count: got %0d required 4", xq.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         exp = {i == 0, i == 3, 8'h20 + 8'(i)};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_post%0d: got %h required %h", i, got, exp);
         end
      end
   endtask

   task automatic test_zero_length();
      sel = 0;
      apply_reset();
      plen = 11'd0; ready = 1'b1; en = 1'b1;
      base = xq.size();
      tick();
      for (int i = 0; i < 3; i++) strobe_byte(8'hC1 + 8'(i), 1'b0, 4'h0);
      wait_xfers(base, 3, 40);
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (xq.size() - base !== 3) begin
         tests_failed++;
         $display("FAIL zlen_count: got %0d required 3", xq.size() - base);
      end
      for (int i = 0; i < 3; i++) begin
         exp = {1'b1, 1'b1, 8'hC1 + 8'(i)};
         got = (base + i < xq.size()) ? xq[base + i] : 10'h3FF;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL zlen_byte%0d: got %h required %h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lanes8_packets();
      test_lanes1_tail();
      test_backpressure();
      test_overflow();
      test_reset_mid_packet();
      test_zero_length();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
